// File: rtl/tmds_encoder.sv
// DVI TMDS encoder: expands BPC-bit RGB to 8 bits and emits three 10-bit
// symbols per pixel clock through a fixed two-stage pipeline.
module tmds_encoder #(
    parameter int BPC = 5
) (
    input  logic           clk_pix,
    input  logic           rst_pix,
    input  logic           de,
    input  logic           hsync,
    input  logic           vsync,
    input  logic [BPC-1:0] r,
    input  logic [BPC-1:0] g,
    input  logic [BPC-1:0] b,
    output logic [9:0]     tmds_ch0,
    output logic [9:0]     tmds_ch1,
    output logic [9:0]     tmds_ch2
);

    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;

    logic [7:0] r8, g8, b8;

    generate
        if (BPC == 8) begin : g_pass
            assign r8 = r;
            assign g8 = g;
            assign b8 = b;
        end else begin : g_rep
            assign r8 = {r, r[BPC-1 -: 8-BPC]};
            assign g8 = {g, g[BPC-1 -: 8-BPC]};
            assign b8 = {b, b[BPC-1 -: 8-BPC]};
        end
    endgenerate

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Transition minimisation: choose XOR or XNOR chaining, flagged in q_m[8].
    function automatic logic [8:0] tm_stage1(input logic [7:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Returns {next_cnt[4:0], symbol[9:0]}; all sums are 6-bit two's complement.
    function automatic logic [14:0] tm_stage2(input logic [8:0] qm, input logic [4:0] cnt);
        logic [3:0] n1, n0;
        logic [5:0] diff, cnt6, nxt;
        logic [9:0] sym;
        n1   = ones8(qm[7:0]);
        n0   = 4'd8 - n1;
        diff = {2'b00, n1} - {2'b00, n0};
        cnt6 = {cnt[4], cnt};
        if ((cnt == 5'd0) || (n1 == n0)) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            nxt = qm[8] ? (cnt6 + diff) : (cnt6 - diff);
        end else if ((!cnt[4] && (n1 > n0)) || (cnt[4] && (n0 > n1))) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            nxt = cnt6 + {4'd0, qm[8], 1'b0} - diff;
        end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            nxt = cnt6 - {4'd0, ~qm[8], 1'b0} + diff;
        end
        return {nxt[4:0], sym};
    endfunction

    logic [8:0] qm_r_q, qm_r_d, qm_g_q, qm_g_d, qm_b_q, qm_b_d;
    logic       de_s1_q, de_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
    logic [9:0] ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d;
    logic [4:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    always_comb begin
        qm_r_d  = tm_stage1(r8);
        qm_g_d  = tm_stage1(g8);
        qm_b_d  = tm_stage1(b8);
        de_s1_d = de;
        hs_s1_d = hsync;
        vs_s1_d = vsync;
    end

    always_comb begin
        cnt0_d = 5'd0;
        cnt1_d = 5'd0;
        cnt2_d = 5'd0;
        ch0_d  = CTL_00;
        ch1_d  = CTL_00;
        ch2_d  = CTL_00;
        if (de_s1_q) begin
            {cnt0_d, ch0_d} = tm_stage2(qm_b_q, cnt0_q);
            {cnt1_d, ch1_d} = tm_stage2(qm_g_q, cnt1_q);
            {cnt2_d, ch2_d} = tm_stage2(qm_r_q, cnt2_q);
        end else begin
            // Only the blue lane carries sync during blanking.
            case ({vs_s1_q, hs_s1_q})
                2'b00:   ch0_d = CTL_00;
                2'b01:   ch0_d = CTL_01;
                2'b10:   ch0_d = CTL_10;
                default: ch0_d = CTL_11;
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix) begin
        if (!rst_pix) begin
            qm_r_q  <= 9'd0;
            qm_g_q  <= 9'd0;
            qm_b_q  <= 9'd0;
            de_s1_q <= 1'b0;
            hs_s1_q <= 1'b0;
            vs_s1_q <= 1'b0;
            ch0_q   <= CTL_00;
            ch1_q   <= CTL_00;
            ch2_q   <= CTL_00;
            cnt0_q  <= 5'd0;
            cnt1_q  <= 5'd0;
            cnt2_q  <= 5'd0;
        end else begin
            qm_r_q  <= qm_r_d;
            qm_g_q  <= qm_g_d;
            qm_b_q  <= qm_b_d;
            de_s1_q <= de_s1_d;
            hs_s1_q <= hs_s1_d;
            vs_s1_q <= vs_s1_d;
            ch0_q   <= ch0_d;
            ch1_q   <= ch1_d;
            ch2_q   <= ch2_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
        end
    end

    assign tmds_ch0 = ch0_q;
    assign tmds_ch1 = ch1_q;
    assign tmds_ch2 = ch2_q;

endmodule
